// File: rtl/wb_ram_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-RAM bridge and other byte-select adapters.
package wb_ram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    RMW_ISSUE,
    RMW_DATA,
    WR,
    ACK
  } state_e;

  // Widest word the generic byte merge handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_SEL_W  = MAX_DATA_W / 8;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

  // Bytes with sel set come from new_w, the rest keep old_w.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_SEL_W-1:0]  sel
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_SEL_W; b++)
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_ram_bridge_if.sv
// Wishbone-classic bus bundle between an interconnect master and the RAM bridge.
interface wb_ram_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [SEL_W-1:0]  wb_sel_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_ram_bridge.sv
// Wishbone-classic slave serialising bus transfers onto a 1-cycle-latency dual-port RAM,
// with byte-select writes done as read-modify-write.
module wb_ram_bridge
  import wb_ram_bridge_pkg::*;
#(
  parameter int RAM_WORDS_SIZE = 256,
  parameter int DATA_W         = 32,
  localparam int ADDR_W        = log2c(RAM_WORDS_SIZE),
  localparam int SEL_W         = sel_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_ram_bridge_if.slave    wb,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_w_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [ADDR_W-1:0] ram_r_addr_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  state_e            state;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] rdat_q;
  logic              ack_q;
  logic [DATA_W-1:0] merged;

  assign merged = DATA_W'(byte_merge(MAX_DATA_W'(ram_data_i), MAX_DATA_W'(dat_q),
                                     MAX_SEL_W'(sel_q)));

  assign ram_r_addr_o = adr_q;
  assign ram_w_addr_o = adr_q;
  assign wb.wb_dat_o  = rdat_q;
  assign wb.wb_ack_o  = ack_q;

  // ram_data_o doubles as the merge register for partial writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i) begin
            adr_q <= wb.wb_adr_i;
            dat_q <= wb.wb_dat_i;
            sel_q <= wb.wb_sel_i;
            if (!wb.wb_we_i) begin
              state <= RD_ISSUE;
            end else if (&wb.wb_sel_i) begin
              ram_data_o <= wb.wb_dat_i;
              ram_we_o   <= 1'b1;
              state      <= WR;
            end else if (wb.wb_sel_i == '0) begin
              ack_q <= 1'b1;
              state <= ACK;
            end else begin
              state <= RMW_ISSUE;
            end
          end
        end
        RD_ISSUE: state <= wb.wb_cyc_i ? RD_DATA : IDLE;
        RD_DATA: begin
          if (!wb.wb_cyc_i) begin
            state <= IDLE;
          end else begin
            rdat_q <= ram_data_i;
            ack_q  <= 1'b1;
            state  <= ACK;
          end
        end
        RMW_ISSUE: state <= wb.wb_cyc_i ? RMW_DATA : IDLE;
        RMW_DATA: begin
          if (!wb.wb_cyc_i) begin
            state <= IDLE;
          end else begin
            ram_data_o <= merged;
            ram_we_o   <= 1'b1;
            state      <= WR;
          end
        end
        // Once the write strobe is out the transfer is committed, cyc or not.
        WR: begin
          ram_we_o <= 1'b0;
          ack_q    <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Bench for wb_ram_bridge: behavioural RAM, table-driven transfers scored through a queue,
// plus hand sequences for abort and mid-transfer reset.
module tb_wb_ram_bridge;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd, ram_rd;
  logic [DW-1:0] mem [256];

  wb_ram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_ram_bridge #(.RAM_WORDS_SIZE(256), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .wb           (bus),
    .ram_we_o     (ram_we),
    .ram_w_addr_o (ram_wa),
    .ram_data_o   (ram_wd),
    .ram_r_addr_o (ram_ra),
    .ram_data_i   (ram_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    ram_rd <= mem[ram_ra];
  end

  int            wr_cnt = 0;
  logic [AW-1:0] last_wa = '0;
  always @(negedge clk) begin
    if (ram_we) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = ram_wa;
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    bit            scr;
    int            lat;
    int            nw;
    logic [DW-1:0] rd;
  } vec_t;

  typedef struct {
    int            lat;
    int            nw;
    logic [DW-1:0] rd;
    logic [AW-1:0] wa;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
  endtask

  // Drive stb in cycle 0, return the cycle index at which ack is seen high (0 = none).
  task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [3:0] sel, input bit scr, output int lat,
                      output logic [DW-1:0] rd, output int nw, output logic [AW-1:0] wa);
    int w0;
    w0  = wr_cnt;
    lat = 0;
    rd  = '0;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scr) begin
        bus.wb_we_i  = ~we;
        bus.wb_adr_i = AW'($urandom);
        bus.wb_dat_i = $urandom;
        bus.wb_sel_i = 4'($urandom);
      end
      if (bus.wb_ack_o) begin
        lat = k;
        rd  = bus.wb_dat_o;
        break;
      end
    end
    idle_bus();
    @(posedge clk); #1;
    chk("ack_pulse", {31'd0, bus.wb_ack_o}, 32'd0);
    nw = wr_cnt - w0;
    wa = last_wa;
  endtask

  vec_t          tbl [13];
  exp_t          e;
  int            lat, nw, w0;
  logic [DW-1:0] rd;
  logic [AW-1:0] wa;

  initial begin
    tbl[0]  = '{1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 3, 0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 8'h20, 32'h12345678, 4'hF, 1'b0, 2, 1, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 3, 0, 32'h12345678};
    tbl[3]  = '{1'b1, 8'h30, 32'h11223344, 4'h5, 1'b0, 4, 1, 32'h12345678};
    tbl[4]  = '{1'b0, 8'h30, 32'h0,        4'h0, 1'b0, 3, 0, 32'hAA22CC44};
    tbl[5]  = '{1'b1, 8'h40, 32'h55555555, 4'h0, 1'b0, 1, 0, 32'hAA22CC44};
    tbl[6]  = '{1'b0, 8'h40, 32'h0,        4'h0, 1'b0, 3, 0, 32'hCAFEF00D};
    tbl[7]  = '{1'b1, 8'h50, 32'h99887766, 4'hA, 1'b1, 4, 1, 32'hCAFEF00D};
    tbl[8]  = '{1'b0, 8'h50, 32'h0,        4'h0, 1'b0, 3, 0, 32'h99027704};
    tbl[9]  = '{1'b1, 8'hFF, 32'hA5A5A5A5, 4'hF, 1'b0, 2, 1, 32'h99027704};
    tbl[10] = '{1'b0, 8'hFF, 32'h0,        4'h0, 1'b0, 3, 0, 32'hA5A5A5A5};
    tbl[11] = '{1'b1, 8'h00, 32'h7F000000, 4'h8, 1'b0, 4, 1, 32'hA5A5A5A5};
    tbl[12] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 3, 0, 32'h7F000000};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hAABBCCDD;
    mem[8'h40] = 32'hCAFEF00D;
    mem[8'h50] = 32'h01020304;
    idle_bus();

    #17;
    chk("rst_ack",   {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_dat",   bus.wb_dat_o, 32'd0);
    chk("rst_we",    {31'd0, ram_we}, 32'd0);
    chk("rst_raddr", {24'd0, ram_ra}, 32'd0);
    chk("rst_waddr", {24'd0, ram_wa}, 32'd0);
    chk("rst_wdata", ram_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sb.push_back('{tbl[i].lat, tbl[i].nw, tbl[i].rd, tbl[i].adr});
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].scr, lat, rd, nw, wa);
      e = sb.pop_front();
      if (lat == 0) begin
        total++;
        bad++;
        $display("FAIL ack_timeout vec %0d: no ack within 12 cycles, want latency %0d", i, e.lat);
      end else begin
        chk($sformatf("latency[%0d]", i), lat, e.lat);
        chk($sformatf("rdata[%0d]", i), rd, e.rd);
      end
      chk($sformatf("nwrites[%0d]", i), nw, e.nw);
      if (e.nw != 0) chk($sformatf("waddr[%0d]", i), {24'd0, wa}, {24'd0, e.wa});
    end

    // Partial write abandoned in RMW_DATA: no ack, no RAM write, old data survives.
    w0 = wr_cnt;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 8'h30; bus.wb_dat_i = 32'hFFFFFFFF; bus.wb_sel_i = 4'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_bus();
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) lat = 1;
    end
    chk("abort_ack", lat, 0);
    chk("abort_nwr", wr_cnt - w0, 0);
    xfer(1'b0, 8'h30, 32'h0, 4'h0, 1'b0, lat, rd, nw, wa);
    chk("abort_rd_lat", lat, 3);
    chk("abort_rd_dat", rd, 32'hAA22CC44);

    // Reset while the read data is being returned.
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 8'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("midrst_dat", bus.wb_dat_o, 32'd0);
    chk("midrst_we",  {31'd0, ram_we}, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, lat, rd, nw, wa);
    chk("postrst_lat", lat, 3);
    chk("postrst_dat", rd, 32'hDEADBEEF);
    chk("postrst_nwr", nw, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ram_bridge.md
Name: wb_ram_bridge

Overview:
Wishbone-classic slave that fronts a dual-port synchronous RAM (1-cycle registered read, whole-word write, no byte enables) and acts as its sole initiator. It serialises bus reads and writes onto the RAM read and write ports. It implements byte-select writes via read-modify-write. It sits between the core/data bus interconnect and each on-chip RAM instance.

Parameters:
RAM_WORDS_SIZE, 256, RAM depth in words; ADDR_W = log2(RAM_WORDS_SIZE) via shared log2 helper
DATA_W, 32, word width; must be multiple of 8; SEL_W = DATA_W/8

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe/request
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  ADDR_W  word address
wb_dat_i  in  DATA_W  write data
wb_sel_i  in  SEL_W  byte selects
wb_dat_o  out  DATA_W  read data (registered)
wb_ack_o  out  1  transfer acknowledge (registered, 1-cycle pulse)
ram_we_o  out  1  RAM write enable
ram_w_addr_o  out  ADDR_W  RAM write address
ram_data_o  out  DATA_W  RAM write data
ram_r_addr_o  out  ADDR_W  RAM read address
ram_data_i  in  DATA_W  RAM read data, valid the cycle after ram_r_addr_o is presented

Behaviour:
- Clock clk_i; reset rst_n_i is asynchronous, active-low. On reset, state=IDLE. All outputs and internal regs are 0: wb_ack_o, wb_dat_o, ram_we_o, addresses, ram_data_o.
- All outputs are registered. ram_r_addr_o and ram_w_addr_o both carry the latched address register.
- FSM states: IDLE, RD_ISSUE, RD_DATA, RMW_ISSUE, RMW_DATA, WR, ACK.
- IDLE, when cyc&stb: latch adr/dat/sel/we.
  - Read -> RD_ISSUE.
  - Write with sel all ones -> WR.
  - Write with sel==0 -> ACK, no RAM write.
  - Other write -> RMW_ISSUE.
- RD_ISSUE: address presented to RAM -> RD_DATA.
- RD_DATA: wb_dat_o <= ram_data_i; wb_ack_o <= 1 -> ACK.
- RMW_ISSUE -> RMW_DATA.
- RMW_DATA: merge register <= per byte b: sel[b] ? dat[b] : ram_data_i[b] -> WR.
- WR: ram_we_o=1 for exactly one cycle with ram_data_o = full write data or merged word; wb_ack_o <= 1 -> ACK.
- ACK: wb_ack_o high this one cycle; wb_ack_o <= 0 -> IDLE. A request still asserted in IDLE is treated as new; masters must drop stb after ack.
- Latency, stb assertion (cycle 0) to ack-high cycle:
  - read: 3
  - full write: 2
  - partial write: 4
  - sel==0 write: 1
- ram_we_o is never high outside WR. At most one RAM write per bus write.
- wb_dat_o holds the last read data until the next read completes. It is not modified by writes.
- Abort: cyc deasserted in RD_ISSUE, RD_DATA, RMW_ISSUE or RMW_DATA -> IDLE next cycle, no ack, no write. WR is not abortable; the write completes and ack is still generated.
- Inputs are sampled only in IDLE and RMW_DATA, and only from latched copies. Bus changes mid-transaction have no effect.
- Reset asserted mid-transaction: immediate return to IDLE. ram_we_o drops asynchronously; a partially merged write is discarded.
- Address wrap is not applicable: ADDR_W exactly spans the RAM.

Decomposition:
- Shared package holds:
  - state enum
  - SEL_W derivation
  - byte-merge function (old word, new word, sel -> merged word), reusable by other byte-select adapters
- No sub-module beyond the FSM. The RAM is instantiated by the parent, not inside the bridge.

Test Plan:
- Preload word 0x10=0xDEADBEEF; read 0x10 -> ack 3 cycles after stb, wb_dat_o=0xDEADBEEF, ram_we_o never asserted.
- Write 0x20=0x12345678, sel=4'hF -> single ram_we_o pulse with addr 0x20, ack at cycle 2; read back 0x12345678.
- Word 0x30=0xAABBCCDD; write 0x11223344, sel=4'b0101 -> ack at cycle 4; RAM holds 0xAA22CC44.
- Write sel=4'h0 to 0x40 -> ack at cycle 1, ram_we_o stays 0, contents unchanged.
- Partial write, cyc dropped during RMW_DATA -> no ack, no write, FSM in IDLE; a following read of the same address returns the old value.
- Assert rst_n_i low during RD_DATA -> wb_ack_o=0, wb_dat_o=0, state IDLE. After release, a fresh read succeeds.
